// File: rtl/sha3_pad_buffer_if.sv
// -----------------------------------------------------------------------------
// sha3_pad_buffer_if
// Purpose : Bundles the message-word input stream and the rate-block output
//           stream of sha3_pad_buffer into one interface.
// Signals :
//   in_data     64        message word, byte i at bits [8i+7:8i]
//   in_bytes    4         valid bytes in a final word (0..8, >8 means 8)
//   in_last     1         final word of the message
//   in_valid    1         word present
//   in_ready    1         buffer can accept a word this cycle
//   block       64*RW     rate block, lane k at bits [64k+63:64k]
//   block_valid 1         block holds a complete block
//   block_last  1         block is the final, padded block of the message
//   block_ready 1         consumer takes the block this cycle
// Modports:
//   slave  - the pad buffer itself
//   master - the message source plus the absorb-stage consumer
// -----------------------------------------------------------------------------
interface sha3_pad_buffer_if #(
    parameter int RATE_WORDS = 17
);
    localparam int BLOCK_W = 64 * RATE_WORDS;

    logic [63:0]        in_data;
    logic [3:0]         in_bytes;
    logic               in_last;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] block;
    logic               block_valid;
    logic               block_last;
    logic               block_ready;

    modport slave (
        input  in_data,
        input  in_bytes,
        input  in_last,
        input  in_valid,
        output in_ready,
        output block,
        output block_valid,
        output block_last,
        input  block_ready
    );

    modport master (
        output in_data,
        output in_bytes,
        output in_last,
        output in_valid,
        input  in_ready,
        input  block,
        input  block_valid,
        input  block_last,
        output block_ready
    );
endinterface

// File: rtl/sha3_pad_buffer.sv
// -----------------------------------------------------------------------------
// sha3_pad_buffer
// Purpose : Upstream feeder for the SHA3 absorb pipeline. Packs a stream of
//           64-bit little-endian message words into rate blocks of
//           64*RATE_WORDS bits and applies Keccak multi-rate padding
//           (DOMAIN_BYTE after the last message byte, 0x80 in the final rate
//           byte). Each block is held until the absorb stage takes it.
// Ports   :
//   clk    in   single clock, all state on the rising edge
//   reset  in   asynchronous active-high reset, clears all state
//   bus    --   sha3_pad_buffer_if.slave (word input stream, block output)
// Notes   :
//   - When a message ends exactly on a block boundary the data block goes
//     out unpadded and a pad-only block follows it.
//   - The block register is cleared every time the buffer returns to
//     collecting, so lanes never written in a block read as zero and
//     padding can simply be OR'ed in.
// -----------------------------------------------------------------------------
module sha3_pad_buffer #(
    parameter int         RATE_WORDS  = 17,
    parameter logic [7:0] DOMAIN_BYTE = 8'h06
) (
    input  logic              clk,
    input  logic              reset,
    sha3_pad_buffer_if.slave  bus
);

    localparam int BLOCK_W    = 64 * RATE_WORDS;
    localparam int RATE_BYTES = 8 * RATE_WORDS;
    localparam int CNT_W      = $clog2(RATE_WORDS);
    localparam int POS_W      = CNT_W + 4;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_OUT     = 1'b1
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   word_cnt_r;
    logic               extra_pend_r;
    logic               in_ready_r;
    logic [BLOCK_W-1:0] block_r;
    logic               block_valid_r;
    logic               block_last_r;

    logic               accept_s;
    logic [3:0]         n_bytes_s;
    logic [63:0]        masked_word_s;
    logic [POS_W-1:0]   pad_pos_s;
    logic               exact_fill_s;
    logic [BLOCK_W-1:0] lane_block_s;
    logic [BLOCK_W-1:0] padded_block_s;
    logic [BLOCK_W-1:0] pad_only_block_s;

    // Keep the low n bytes of a word and force the bytes above n to zero.
    function automatic logic [63:0] mask_word(input logic [63:0] data,
                                              input logic [3:0]  n);
        logic [63:0] res;
        res = 64'h0;
        for (int i = 0; i < 8; i++) begin
            res[8*i +: 8] = (4'(i) < n) ? data[8*i +: 8] : 8'h00;
        end
        return res;
    endfunction

    // Build the candidate next block contents for the word on the bus.
    always_comb begin
        accept_s = bus.in_valid & in_ready_r;

        // Non-final words always carry 8 bytes; final words clamp to 8.
        if (!bus.in_last) begin
            n_bytes_s = 4'd8;
        end else if (bus.in_bytes > 4'd8) begin
            n_bytes_s = 4'd8;
        end else begin
            n_bytes_s = bus.in_bytes;
        end

        masked_word_s = mask_word(bus.in_data, n_bytes_s);

        // Byte offset of the first pad byte within the block.
        pad_pos_s    = (POS_W'(word_cnt_r) << 3) + POS_W'(n_bytes_s);
        exact_fill_s = (pad_pos_s == POS_W'(RATE_BYTES));

        lane_block_s = block_r;
        for (int k = 0; k < RATE_WORDS; k++) begin
            lane_block_s[64*k +: 64] = (CNT_W'(k) == word_cnt_r) ?
                                       masked_word_s : block_r[64*k +: 64];
        end

        padded_block_s = lane_block_s;
        for (int j = 0; j < RATE_BYTES; j++) begin
            padded_block_s[8*j +: 8] = lane_block_s[8*j +: 8] |
                ((POS_W'(j) == pad_pos_s) ? DOMAIN_BYTE : 8'h00);
        end
        // OR rather than assign: when the domain byte lands on the last
        // byte the two pad bytes merge (0x06 | 0x80 = 0x86).
        padded_block_s[BLOCK_W-1 -: 8] = padded_block_s[BLOCK_W-1 -: 8] | 8'h80;

        pad_only_block_s                 = {BLOCK_W{1'b0}};
        pad_only_block_s[7:0]            = DOMAIN_BYTE;
        pad_only_block_s[BLOCK_W-1 -: 8] = 8'h80;
    end

    // Collect/output state machine with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_COLLECT;
            word_cnt_r    <= {CNT_W{1'b0}};
            extra_pend_r  <= 1'b0;
            in_ready_r    <= 1'b0;
            block_r       <= {BLOCK_W{1'b0}};
            block_valid_r <= 1'b0;
            block_last_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (!in_ready_r) begin
                        // First edge after reset release: open the input.
                        in_ready_r <= 1'b1;
                    end else if (accept_s) begin
                        if (!bus.in_last) begin
                            block_r <= lane_block_s;
                            if (word_cnt_r == CNT_W'(RATE_WORDS - 1)) begin
                                state_r       <= ST_OUT;
                                in_ready_r    <= 1'b0;
                                block_valid_r <= 1'b1;
                                block_last_r  <= 1'b0;
                                word_cnt_r    <= {CNT_W{1'b0}};
                            end else begin
                                word_cnt_r <= word_cnt_r + CNT_W'(1);
                            end
                        end else begin
                            state_r       <= ST_OUT;
                            in_ready_r    <= 1'b0;
                            block_valid_r <= 1'b1;
                            word_cnt_r    <= {CNT_W{1'b0}};
                            if (exact_fill_s) begin
                                // Message filled the block exactly: padding
                                // goes into a follow-on pad-only block.
                                block_r      <= lane_block_s;
                                block_last_r <= 1'b0;
                                extra_pend_r <= 1'b1;
                            end else begin
                                block_r      <= padded_block_s;
                                block_last_r <= 1'b1;
                            end
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end

                ST_OUT: begin
                    if (bus.block_ready) begin
                        if (extra_pend_r) begin
                            block_r      <= pad_only_block_s;
                            block_last_r <= 1'b1;
                            extra_pend_r <= 1'b0;
                        end else begin
                            state_r       <= ST_COLLECT;
                            in_ready_r    <= 1'b1;
                            block_r       <= {BLOCK_W{1'b0}};
                            block_valid_r <= 1'b0;
                            block_last_r  <= 1'b0;
                            word_cnt_r    <= {CNT_W{1'b0}};
                        end
                    end else begin
                        block_valid_r <= 1'b1;
                    end
                end

                default: begin
                    state_r       <= ST_COLLECT;
                    word_cnt_r    <= {CNT_W{1'b0}};
                    extra_pend_r  <= 1'b0;
                    in_ready_r    <= 1'b0;
                    block_r       <= {BLOCK_W{1'b0}};
                    block_valid_r <= 1'b0;
                    block_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.block       = block_r;
    assign bus.block_valid = block_valid_r;
    assign bus.block_last  = block_last_r;

endmodule

// File: tb/tb_sha3_pad_buffer.sv
// -----------------------------------------------------------------------------
// tb_sha3_pad_buffer
// Directed bench for sha3_pad_buffer (SHA3-256 configuration, 17 lanes).
// Expected blocks are written out by hand from the padding rules.
// -----------------------------------------------------------------------------
module tb_sha3_pad_buffer;

    localparam int RW      = 17;
    localparam int BLOCK_W = 64 * RW;

    logic clk = 1'b0;
    logic reset;

    int vectors    = 0;
    int miscompares = 0;

    sha3_pad_buffer_if #(.RATE_WORDS(RW)) ifc ();

    sha3_pad_buffer #(.RATE_WORDS(RW), .DOMAIN_BYTE(8'h06)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Deterministic message word for lane k.
    function automatic logic [63:0] w(int k);
        return 64'h1111_1111_1111_1111 * 64'(k + 1);
    endfunction

    task automatic chk1(string tag, logic obs, logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(string tag, logic [BLOCK_W-1:0] exp);
        int bad;
        bad = 0;
        for (int k = RW - 1; k >= 0; k--) begin
            if (ifc.block[64*k +: 64] !== exp[64*k +: 64]) bad = k;
        end
        vectors++;
        assert (ifc.block === exp) else begin
            miscompares++;
            $error("FAIL %s: lane %0d observed %h expected %h", tag, bad,
                   ifc.block[64*bad +: 64], exp[64*bad +: 64]);
        end
    endtask

    // Offer one word and wait (bounded) for it to be accepted.
    task automatic send(logic [63:0] d, logic [3:0] b, logic l);
        int t;
        t = 0;
        @(negedge clk);
        ifc.in_data  = d;
        ifc.in_bytes = b;
        ifc.in_last  = l;
        ifc.in_valid = 1'b1;
        while (ifc.in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk1("send_in_ready", ifc.in_ready, 1'b1);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic write_blk();
        @(negedge clk);
        ifc.block_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.block_ready = 1'b0;
    endtask

    logic [BLOCK_W-1:0] exp_empty, exp_abc, exp_b, zero_blk;

    initial begin
        reset           = 1'b1;
        ifc.in_data     = 64'h0;
        ifc.in_bytes    = 4'd0;
        ifc.in_last     = 1'b0;
        ifc.in_valid    = 1'b0;
        ifc.block_ready = 1'b0;

        zero_blk = '0;
        exp_empty = '0;
        exp_empty[7:0]           = 8'h06;
        exp_empty[1087:1080]     = 8'h80;
        exp_abc = '0;
        exp_abc[63:0]            = 64'h0000_0000_0663_6261;
        exp_abc[1087:1080]       = 8'h80;

        // Reset values
        #2;
        chk1("rst_in_ready", ifc.in_ready, 1'b0);
        chk1("rst_valid", ifc.block_valid, 1'b0);
        chk1("rst_last", ifc.block_last, 1'b0);
        chk_blk("rst_block", zero_blk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("rel_in_ready_low", ifc.in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk1("rel_in_ready_high", ifc.in_ready, 1'b1);

        // 1. Empty message
        send(64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b1);
        chk1("empty_valid", ifc.block_valid, 1'b1);
        chk1("empty_last", ifc.block_last, 1'b1);
        chk1("empty_in_ready", ifc.in_ready, 1'b0);
        chk_blk("empty_block", exp_empty);
        write_blk();
        chk1("empty_wr_valid", ifc.block_valid, 1'b0);
        chk1("empty_wr_in_ready", ifc.in_ready, 1'b1);
        chk_blk("empty_wr_block", zero_blk);

        // 2. "abc"
        send(64'h0000_0000_0063_6261, 4'd3, 1'b1);
        chk1("abc_valid", ifc.block_valid, 1'b1);
        chk1("abc_last", ifc.block_last, 1'b1);
        chk_blk("abc_block", exp_abc);
        write_blk();

        // 3. 135-byte message: domain and final pad bytes merge to 0x86
        for (int k = 0; k < 16; k++) send(w(k), 4'd8, 1'b0);
        chk1("m135_not_yet_valid", ifc.block_valid, 1'b0);
        send(64'hFFEE_DDCC_BBAA_9988, 4'd7, 1'b1);
        exp_b = '0;
        for (int k = 0; k < 16; k++) exp_b[64*k +: 64] = w(k);
        exp_b[1087:1024] = 64'h86EE_DDCC_BBAA_9988;
        chk1("m135_valid", ifc.block_valid, 1'b1);
        chk1("m135_last", ifc.block_last, 1'b1);
        chk_blk("m135_block", exp_b);
        write_blk();

        // 4. 136-byte message (in_bytes=15 clamps to 8): raw block then pad block
        for (int k = 0; k < 16; k++) send(w(k), 4'd8, 1'b0);
        send(w(16), 4'd15, 1'b1);
        exp_b = '0;
        for (int k = 0; k < 17; k++) exp_b[64*k +: 64] = w(k);
        chk1("m136_valid", ifc.block_valid, 1'b1);
        chk1("m136_last0", ifc.block_last, 1'b0);
        chk1("m136_in_ready0", ifc.in_ready, 1'b0);
        chk_blk("m136_block0", exp_b);
        write_blk();
        chk1("m136_valid1", ifc.block_valid, 1'b1);
        chk1("m136_last1", ifc.block_last, 1'b1);
        chk1("m136_in_ready1", ifc.in_ready, 1'b0);
        chk_blk("m136_block1", exp_empty);
        write_blk();
        chk1("m136_done_valid", ifc.block_valid, 1'b0);
        chk1("m136_done_in_ready", ifc.in_ready, 1'b1);

        // 5. Backpressure with a word offered while the block is held
        send(64'h0123_4567_89AB_CDEF, 4'd8, 1'b0);
        send(64'h5555_5555_5555_2211, 4'd2, 1'b1);
        exp_b = '0;
        exp_b[63:0]        = 64'h0123_4567_89AB_CDEF;
        exp_b[127:64]      = 64'h0000_0000_0006_2211;
        exp_b[1087:1080]   = 8'h80;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ifc.in_data  = 64'hDEAD_BEEF_CAFE_F00D;
            ifc.in_bytes = 4'd8;
            ifc.in_last  = 1'b1;
            ifc.in_valid = 1'b1;
            chk1("bp_valid", ifc.block_valid, 1'b1);
            chk1("bp_last", ifc.block_last, 1'b1);
            chk1("bp_in_ready", ifc.in_ready, 1'b0);
            chk_blk("bp_block", exp_b);
        end
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        write_blk();
        chk1("bp_wr_valid", ifc.block_valid, 1'b0);
        chk1("bp_wr_in_ready", ifc.in_ready, 1'b1);
        chk_blk("bp_wr_block", zero_blk);

        // 6a. Reset while a data block is out with a pad block pending
        for (int k = 0; k < 17; k++) send(w(k), 4'd8, k == 16);
        chk1("rso_valid_before", ifc.block_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("rso_valid", ifc.block_valid, 1'b0);
        chk_blk("rso_block", zero_blk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk1("rso_after_valid", ifc.block_valid, 1'b0);
        chk1("rso_after_in_ready", ifc.in_ready, 1'b1);

        // 6. Reset mid-collection, then "abc" must match test 2 exactly
        for (int k = 0; k < 5; k++) send(w(k), 4'd8, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk1("rsc_valid", ifc.block_valid, 1'b0);
        chk1("rsc_in_ready", ifc.in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(64'h0000_0000_0063_6261, 4'd3, 1'b1);
        chk1("rsc_abc_valid", ifc.block_valid, 1'b1);
        chk1("rsc_abc_last", ifc.block_last, 1'b1);
        chk_blk("rsc_abc_block", exp_abc);
        write_blk();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
